// File: rtl/jpeg_bit_unpacker_if.sv
// Byte-in / bit-out stream bundle between the scan byte source, the unpacker
// and the downstream Huffman decoder.
interface jpeg_bit_unpacker_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       out_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       marker_found;
    logic [7:0] marker_code;

    modport master (
        output byte_in,
        output byte_valid,
        output out_ready,
        input  byte_ready,
        input  bit_out,
        input  bit_valid,
        input  marker_found,
        input  marker_code
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        input  out_ready,
        output byte_ready,
        output bit_out,
        output bit_valid,
        output marker_found,
        output marker_code
    );
endinterface

// File: rtl/jpeg_bit_unpacker.sv
// JPEG entropy-coded segment front end: strips 0xFF00 stuffing and fill bytes,
// halts on markers and serialises data bytes MSB-first for the Huffman decoder.
module jpeg_bit_unpacker #(
    parameter bit FILL_SKIP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    jpeg_bit_unpacker_if.slave   bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SHIFT   = 2'd1,
        FF_HOLD = 2'd2,
        MARKER  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic [7:0] code;
    logic [7:0] code_nxt;
    logic       byte_done;
    logic       byte_accept;

    // Last bit leaving this cycle lets the next byte in with no bubble.
    assign byte_done       = (state == SHIFT) && (cnt == 3'd7) && bus.out_ready;
    assign bus.byte_ready  = (state == FETCH) || (state == FF_HOLD) || byte_done;
    assign byte_accept     = bus.byte_valid && bus.byte_ready;

    assign bus.bit_valid    = (state == SHIFT);
    assign bus.bit_out      = shreg[7];
    assign bus.marker_found = (state == MARKER);
    assign bus.marker_code  = code;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            state <= FETCH;
            shreg <= 8'h00;
            cnt   <= 3'd0;
            code  <= 8'h00;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        code_nxt  = code;
        case (state)
            FETCH: begin
                if (byte_accept) begin
                    if (bus.byte_in == 8'hFF) begin
                        state_nxt = FF_HOLD;
                    end else begin
                        shreg_nxt = bus.byte_in;
                        cnt_nxt   = 3'd0;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bus.out_ready) begin
                    shreg_nxt = {shreg[6:0], 1'b0};
                    cnt_nxt   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (byte_accept) begin
                            if (bus.byte_in == 8'hFF) begin
                                state_nxt = FF_HOLD;
                            end else begin
                                shreg_nxt = bus.byte_in;
                                cnt_nxt   = 3'd0;
                                state_nxt = SHIFT;
                            end
                        end else begin
                            state_nxt = FETCH;
                        end
                    end
                end
            end
            FF_HOLD: begin
                // The held 0xFF is only emitted once the stuffing 0x00 confirms it is data.
                if (byte_accept) begin
                    if (bus.byte_in == 8'h00) begin
                        shreg_nxt = 8'hFF;
                        cnt_nxt   = 3'd0;
                        state_nxt = SHIFT;
                    end else if ((bus.byte_in == 8'hFF) && FILL_SKIP) begin
                        state_nxt = FF_HOLD;
                    end else begin
                        code_nxt  = bus.byte_in;
                        state_nxt = MARKER;
                    end
                end
            end
            MARKER: begin
                state_nxt = MARKER;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule
